// File: rtl/cs_energy_avg.sv
// Energy averager: squares I/Q samples, accumulates 2^LOG2N powers, holds the mean,
// and compares it against a threshold on request.
module cs_energy_avg #(
  parameter int unsigned DW    = 16,
  parameter int unsigned LOG2N = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wr_en,
  input  logic signed [DW-1:0] i_in,
  input  logic signed [DW-1:0] q_in,
  input  logic                 rst_dev,
  input  logic                 en_comp,
  input  logic [2*DW:0]        threshold,
  output logic                 ready_sample,
  output logic [2*DW:0]        avg_pwr,
  output logic                 detect,
  output logic                 detect_valid
);

  localparam int unsigned SW = 2 * DW;
  localparam int unsigned PW = 2 * DW + 1;
  localparam int unsigned AW = PW + LOG2N;
  localparam int unsigned CW = LOG2N;

  logic [PW-1:0] pwr_q,     pwr_d;
  logic          pwr_vld_q, pwr_vld_d;
  logic [AW-1:0] acc_q,     acc_d;
  logic [CW-1:0] cnt_q,     cnt_d;
  logic          rdy_q,     rdy_d;
  logic [PW-1:0] avg_q,     avg_d;
  logic          det_q,     det_d;
  logic          dv_q,      dv_d;

  logic signed [SW-1:0] i_ext_c, q_ext_c;
  logic signed [SW-1:0] i_sq_c,  q_sq_c;
  logic [PW-1:0]        pwr_c;
  logic [AW-1:0]        acc_sum_c;
  logic                 accept_c;
  logic                 last_c;

  // Squares are non-negative, so zero-extending them into PW bits cannot wrap.
  always_comb begin
    i_ext_c   = SW'(i_in);
    q_ext_c   = SW'(q_in);
    i_sq_c    = i_ext_c * i_ext_c;
    q_sq_c    = q_ext_c * q_ext_c;
    pwr_c     = PW'($unsigned(i_sq_c)) + PW'($unsigned(q_sq_c));
    acc_sum_c = acc_q + AW'(pwr_q);
    accept_c  = wr_en && !rdy_q && !rst_dev;
    last_c    = (cnt_q == {CW{1'b1}});
  end

  // Next-state: compare uses pre-clear average; rst_dev overrides accumulation.
  always_comb begin
    pwr_d     = pwr_q;
    pwr_vld_d = accept_c;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    rdy_d     = rdy_q;
    avg_d     = avg_q;
    det_d     = det_q;
    dv_d      = 1'b0;

    if (accept_c) begin
      pwr_d = pwr_c;
    end

    if (en_comp && rdy_q) begin
      det_d = (avg_q > threshold);
      dv_d  = 1'b1;
    end

    if (rst_dev) begin
      pwr_vld_d = 1'b0;
      acc_d     = '0;
      cnt_d     = '0;
      rdy_d     = 1'b0;
      avg_d     = '0;
    end else if (pwr_vld_q && !rdy_q) begin
      // A product still in flight when the average completes is dropped here.
      acc_d = acc_sum_c;
      cnt_d = cnt_q + CW'(1);
      if (last_c) begin
        rdy_d = 1'b1;
        avg_d = PW'(acc_sum_c >> LOG2N);
        acc_d = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwr_q     <= '0;
      pwr_vld_q <= 1'b0;
      acc_q     <= '0;
      cnt_q     <= '0;
      rdy_q     <= 1'b0;
      avg_q     <= '0;
      det_q     <= 1'b0;
      dv_q      <= 1'b0;
    end else begin
      pwr_q     <= pwr_d;
      pwr_vld_q <= pwr_vld_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      rdy_q     <= rdy_d;
      avg_q     <= avg_d;
      det_q     <= det_d;
      dv_q      <= dv_d;
    end
  end

  assign ready_sample = rdy_q;
  assign avg_pwr      = avg_q;
  assign detect       = det_q;
  assign detect_valid = dv_q;

endmodule

// File: doc/cs_energy_avg.md
CS_ENERGY_AVG -- requirements
Module: cs_energy_avg

Interface
REQ-001 The block SHALL have parameter DW, default 16, meaning the signed I/Q sample width.
REQ-002 The block SHALL have parameter LOG2N, default 4, meaning log2 of the samples per average (N = 2^LOG2N).
REQ-003 The block SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 The block SHALL have port wr_en  input  1  sample strobe; i_in/q_in are valid when high.
REQ-006 The block SHALL have port i_in  input  DW  signed in-phase sample.
REQ-007 The block SHALL have port q_in  input  DW  signed quadrature sample.
REQ-008 The block SHALL have port rst_dev  input  1  synchronous clear of accumulator, counter and pipeline.
REQ-009 The block SHALL have port en_comp  input  1  one-cycle compare request.
REQ-010 The block SHALL have port threshold  input  2*DW+1  unsigned detection threshold.
REQ-011 The block SHALL have port ready_sample  output  1  level; an N-sample average is available.
REQ-012 The block SHALL have port avg_pwr  output  2*DW+1  unsigned average power.
REQ-013 The block SHALL have port detect  output  1  result of the last comparison.
REQ-014 The block SHALL have port detect_valid  output  1  one-cycle pulse per comparison.

Function
REQ-015 Stage 1 SHALL register pwr = i_in*i_in + q_in*q_in, 2*DW+1 bits unsigned, with a valid bit, one cycle after each accepted wr_en.
REQ-016 Stage 2 SHALL add each valid pwr into an accumulator of 2*DW+1+LOG2N bits and increment the sample counter; no overflow is possible.
REQ-017 A wr_en SHALL be accepted only while ready_sample=0 and rst_dev=0; all other wr_en pulses are ignored.
REQ-018 When the N-th product is accumulated, ready_sample SHALL go high and avg_pwr SHALL load (accumulator + final pwr) >> LOG2N on the same edge, two cycles after the N-th accepted wr_en.
REQ-019 ready_sample and avg_pwr SHALL hold until rst_dev or reset; back-to-back wr_en every cycle is supported.
REQ-020 If en_comp=1 and ready_sample=1, the block SHALL, next cycle, set detect = (avg_pwr > threshold), strictly greater, and pulse detect_valid for exactly one cycle.
REQ-021 If en_comp=1 and ready_sample=0, the block SHALL leave detect unchanged and keep detect_valid=0.
REQ-022 rst_dev=1 SHALL, next cycle, clear accumulator, counter, ready_sample, avg_pwr and the stage-1 valid bit, discarding any in-flight product; detect SHALL be kept.
REQ-023 With en_comp and rst_dev in the same cycle, the comparison SHALL use the pre-clear avg_pwr, and the clear SHALL also take effect.
REQ-024 With wr_en and rst_dev in the same cycle, rst_dev SHALL win and the sample SHALL be dropped.

Reset
REQ-025 rst_n=0 SHALL immediately, without waiting for a clock edge, force: accumulator=0, counter=0, stage-1 valid=0, ready_sample=0, avg_pwr=0, detect=0, detect_valid=0.
REQ-026 After rst_n deasserts mid-accumulation, a full N new accepted samples SHALL be required before ready_sample rises.

Verification
REQ-027 The bench SHALL apply 16 wr_en with I=3, Q=4 -> ready_sample=1 two cycles after the 16th strobe, with avg_pwr=25.
REQ-028 The bench SHALL apply 16 wr_en with I=Q=-32768 -> avg_pwr=2147483648, with no wrap.
REQ-029 The bench SHALL set avg_pwr=25 and pulse en_comp with threshold=25 -> detect=0, then with threshold=24 -> detect=1, with a single-cycle detect_valid each time.
REQ-030 The bench SHALL assert en_comp and rst_dev in one cycle with avg_pwr=25 and threshold=10 -> detect=1 and detect_valid pulse, then ready_sample=0, avg_pwr=0, counter=0.
REQ-031 The bench SHALL drive a 17th wr_en (I=100) after ready_sample=1 -> avg_pwr stays 25.
REQ-032 The bench SHALL drop rst_n asynchronously after 7 samples -> all outputs are 0 before the next edge; after release, 16 samples are needed to reach ready_sample=1.
